// File: rtl/bank_htu_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : bank_htu_req_queue
// Brief    : FIFO between the crossbar and the bank hit-test unit. It tracks
//            occupancy per channel and latches a flag on an illegal channel id.
// Revision : 1.0  initial release
// ============================================================================
module bank_htu_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          xbar_bank_htu_valid_i,
    output logic                          xbar_bank_htu_allowIn_o,
    input  logic [1:0]                    xbar_bank_htu_ch_id_i,
    input  logic [1:0]                    xbar_bank_htu_opcode_i,
    input  logic [31:4]                   xbar_bank_htu_addr_i,
    input  logic [7:0]                    xbar_bank_htu_wbuffer_id_i,
    output logic                          htu_req_valid_o,
    input  logic                          htu_req_ready_i,
    output logic [1:0]                    htu_req_ch_id_o,
    output logic [1:0]                    htu_req_opcode_o,
    output logic [31:4]                   htu_req_addr_o,
    output logic [7:0]                    htu_req_wbuffer_id_o,
    output logic [$clog2(DEPTH):0]        htu_q_count_o,
    output logic [3*($clog2(DEPTH)+1)-1:0] htu_q_ch_cnt_o,
    output logic                          htu_q_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]    ch_mem   [DEPTH];
    logic [1:0]    op_mem   [DEPTH];
    logic [31:4]   addr_mem [DEPTH];
    logic [7:0]    wbid_mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          push, pop;

    // Handshake flags depend on registered occupancy only; no bypass paths.
    assign xbar_bank_htu_allowIn_o = (count_q != FULL);
    assign htu_req_valid_o         = (count_q != '0);
    assign push = xbar_bank_htu_valid_i & xbar_bank_htu_allowIn_o;
    assign pop  = htu_req_valid_o & htu_req_ready_i;

    assign htu_req_ch_id_o      = ch_mem[rptr_q];
    assign htu_req_opcode_o     = op_mem[rptr_q];
    assign htu_req_addr_o       = addr_mem[rptr_q];
    assign htu_req_wbuffer_id_o = wbid_mem[rptr_q];
    assign htu_q_count_o        = count_q;
    assign htu_q_err_o          = err_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        err_d   = err_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && (xbar_bank_htu_ch_id_i == 2'd3)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            ch_mem[wptr_q]   <= xbar_bank_htu_ch_id_i;
            op_mem[wptr_q]   <= xbar_bank_htu_opcode_i;
            addr_mem[wptr_q] <= xbar_bank_htu_addr_i;
            wbid_mem[wptr_q] <= xbar_bank_htu_wbuffer_id_i;
        end
    end

    // Channel 3 is illegal: it never matches a counter here, so those entries
    // flow through the queue without touching per-channel occupancy.
    for (genvar n = 0; n < 3; n++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d;
        logic          inc, dec;

        assign inc = push && (xbar_bank_htu_ch_id_i == 2'(n));
        assign dec = pop  && (htu_req_ch_id_o == 2'(n));

        always_comb begin
            cnt_d = cnt_q;
            case ({inc, dec})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign htu_q_ch_cnt_o[n*CW +: CW] = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_htu_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_htu_req_queue
// Brief    : Scoreboard bench: directed scenarios plus randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_bank_htu_req_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]  ch;
        logic [1:0]  op;
        logic [27:0] addr;
        logic [7:0]  wb;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i, allow_o, valid_o, ready_i, err_o;
    logic [1:0]    ch_i, op_i, ch_o, op_o;
    logic [31:4]   addr_i, addr_o;
    logic [7:0]    wb_i, wb_o;
    logic [CW-1:0] count_o;
    logic [3*CW-1:0] chcnt_o;

    ent_t sb[$];
    logic m_err;
    int   errors = 0;
    int   checks = 0;
    int   max_cnt = 0;

    always #5 clk = ~clk;

    bank_htu_req_queue #(.DEPTH(DEPTH)) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .xbar_bank_htu_valid_i     (valid_i),
        .xbar_bank_htu_allowIn_o   (allow_o),
        .xbar_bank_htu_ch_id_i     (ch_i),
        .xbar_bank_htu_opcode_i    (op_i),
        .xbar_bank_htu_addr_i      (addr_i),
        .xbar_bank_htu_wbuffer_id_i(wb_i),
        .htu_req_valid_o           (valid_o),
        .htu_req_ready_i           (ready_i),
        .htu_req_ch_id_o           (ch_o),
        .htu_req_opcode_o          (op_o),
        .htu_req_addr_o            (addr_o),
        .htu_req_wbuffer_id_o      (wb_o),
        .htu_q_count_o             (count_o),
        .htu_q_ch_cnt_o            (chcnt_o),
        .htu_q_err_o               (err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT hands off its head, it must be the oldest
    // outstanding request.
    always @(negedge clk) begin
        #2;
        if (!rst && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("pop_on_empty_model", 1, 0);
            end else begin
                chk("pop_entry", {ch_o, op_o, addr_o, wb_o}, sb[0]);
                void'(sb.pop_front());
            end
        end
    end

    // One cycle: drive inputs after the edge, then on the falling edge compare
    // registered state against the model and record any accepted request.
    task automatic step(input logic v, input logic [1:0] c, input logic [1:0] o,
                        input logic [27:0] a, input logic [7:0] w,
                        input logic rd, input logic r);
        int n;
        @(posedge clk);
        #1;
        valid_i = v; ch_i = c; op_i = o; addr_i = a; wb_i = w;
        ready_i = rd; rst = r;
        @(negedge clk);
        chk("valid_o", valid_o, sb.size() != 0);
        chk("allowIn_o", allow_o, sb.size() != DEPTH);
        chk("count_o", count_o, sb.size());
        chk("err_o", err_o, m_err);
        for (int ch = 0; ch < 3; ch++) begin
            n = 0;
            foreach (sb[k]) if (sb[k].ch == 2'(ch)) n++;
            chk($sformatf("ch_cnt[%0d]", ch), chcnt_o[ch*CW +: CW], n);
        end
        if (sb.size() != 0) begin
            chk("head_fields", {ch_o, op_o, addr_o, wb_o}, sb[0]);
        end
        if (sb.size() > max_cnt) max_cnt = sb.size();
        if (r) begin
            sb.delete();
            m_err = 1'b0;
        end else if (v && sb.size() != DEPTH) begin
            sb.push_back({c, o, a, w});
            if (c == 2'd3) m_err = 1'b1;
        end
    endtask

    task automatic idle(input logic rd);
        step(1'b0, 2'd0, 2'd0, 28'd0, 8'd0, rd, 1'b0);
    endtask

    initial begin
        int pv, pr;
        m_err = 1'b0;
        valid_i = 0; ch_i = 0; op_i = 0; addr_i = 0; wb_i = 0; ready_i = 0; rst = 1;
        step(1'b0, 2'd0, 2'd0, 28'd0, 8'd0, 1'b1, 1'b1);
        step(1'b1, 2'd1, 2'd1, 28'd1, 8'd1, 1'b1, 1'b1);
        idle(1'b0);

        // Single request, held then consumed.
        step(1'b1, 2'd1, 2'b01, 28'h1234567, 8'h05, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill, blocked fifth push, then full with simultaneous pop and push.
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'(i % 3), 2'(i), 28'(32'h100 + i), 8'(i + 8'h10), 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 2'd2, 2'd3, 28'hABCDEF0, 8'hEE, 1'b1, 1'b0);
        step(1'b1, 2'd2, 2'd3, 28'hABCDEF0, 8'hEE, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Streaming with pointer wrap; occupancy must stay at or below one.
        max_cnt = 0;
        for (int i = 0; i < 10; i++)
            step(1'b1, 2'(i % 3), 2'(i), 28'($urandom), 8'(i), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("stream_max_count", max_cnt, 1);

        // Illegal channel is forwarded and leaves a sticky flag.
        step(1'b1, 2'd3, 2'd2, 28'h0FEDCBA, 8'h33, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'(i), 2'(i), 28'(32'h200 + i), 8'(i), 1'b0, 1'b0);
        step(1'b0, 2'd0, 2'd0, 28'd0, 8'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomized traffic in phases of varying push/pop pressure.
        for (int ph = 0; ph < 8; ph++) begin
            pv = $urandom_range(10, 100);
            pr = $urandom_range(10, 100);
            for (int i = 0; i < 80; i++) begin
                step(($urandom_range(1, 100) <= pv),
                     ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                     2'($urandom), 28'($urandom), 8'($urandom),
                     ($urandom_range(1, 100) <= pr),
                     ($urandom_range(0, 199) == 0));
            end
        end
        for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
